// File: rtl/triangle_rasterizer.sv
// Enumerates every integer point covered by a triangle (edges and vertices included)
// in raster order over the bounding box, streaming them out on a valid/ready port.
module triangle_rasterizer (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] ax,
    input  logic [10:0] ay,
    input  logic [10:0] bx,
    input  logic [10:0] by,
    input  logic [10:0] cx,
    input  logic [10:0] cy,
    output logic [10:0] px,
    output logic [10:0] py,
    output logic        p_valid,
    input  logic        p_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_r;
    logic [10:0] ax_r, ay_r, bx_r, by_r, cx_r, cy_r;
    logic [10:0] xmin_r, xmax_r, ymin_r, ymax_r;
    logic [10:0] x_r, y_r;

    logic [10:0]        bb_xmin_s, bb_xmax_s, bb_ymin_s, bb_ymax_s;
    logic signed [24:0] area_s, e_ab_s, e_bc_s, e_ca_s;
    logic               inside_s, stall_s;

    // (x1-x0)*(yp-y0) - (y1-y0)*(xp-x0), exact: 12-bit differences, 24-bit products, 25-bit sum.
    function automatic logic signed [24:0] edge_fn(
        input logic [10:0] x0, input logic [10:0] y0,
        input logic [10:0] x1, input logic [10:0] y1,
        input logic [10:0] xp, input logic [10:0] yp);
        logic signed [11:0] dx, dy, qx, qy;
        logic signed [23:0] m0, m1;
        dx = $signed({1'b0, x1}) - $signed({1'b0, x0});
        dy = $signed({1'b0, y1}) - $signed({1'b0, y0});
        qx = $signed({1'b0, xp}) - $signed({1'b0, x0});
        qy = $signed({1'b0, yp}) - $signed({1'b0, y0});
        m0 = 24'(dx) * 24'(qy);
        m1 = 24'(dy) * 24'(qx);
        return 25'(m0) - 25'(m1);
    endfunction

    function automatic logic [10:0] min3(input logic [10:0] a, input logic [10:0] b,
                                         input logic [10:0] c);
        logic [10:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [10:0] max3(input logic [10:0] a, input logic [10:0] b,
                                         input logic [10:0] c);
        logic [10:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Bounding box, signed area and the three edge tests for the current candidate.
    always_comb begin
        bb_xmin_s = min3(ax_r, bx_r, cx_r);
        bb_xmax_s = max3(ax_r, bx_r, cx_r);
        bb_ymin_s = min3(ay_r, by_r, cy_r);
        bb_ymax_s = max3(ay_r, by_r, cy_r);
        area_s    = edge_fn(ax_r, ay_r, bx_r, by_r, cx_r, cy_r);
        e_ab_s    = edge_fn(ax_r, ay_r, bx_r, by_r, x_r, y_r);
        e_bc_s    = edge_fn(bx_r, by_r, cx_r, cy_r, x_r, y_r);
        e_ca_s    = edge_fn(cx_r, cy_r, ax_r, ay_r, x_r, y_r);
        // Accepting both signs makes the test independent of vertex winding.
        inside_s  = (!e_ab_s[24] && !e_bc_s[24] && !e_ca_s[24]) ||
                    ((e_ab_s[24] || (e_ab_s == 25'sd0)) &&
                     (e_bc_s[24] || (e_bc_s == 25'sd0)) &&
                     (e_ca_s[24] || (e_ca_s == 25'sd0)));
        stall_s   = p_valid && !p_ready;
    end

    // Control FSM, scan counters and the registered point output.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r <= S_IDLE;
            ax_r    <= 11'd0;
            ay_r    <= 11'd0;
            bx_r    <= 11'd0;
            by_r    <= 11'd0;
            cx_r    <= 11'd0;
            cy_r    <= 11'd0;
            xmin_r  <= 11'd0;
            xmax_r  <= 11'd0;
            ymin_r  <= 11'd0;
            ymax_r  <= 11'd0;
            x_r     <= 11'd0;
            y_r     <= 11'd0;
            px      <= 11'd0;
            py      <= 11'd0;
            p_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        ax_r    <= ax;
                        ay_r    <= ay;
                        bx_r    <= bx;
                        by_r    <= by;
                        cx_r    <= cx;
                        cy_r    <= cy;
                        busy    <= 1'b1;
                        state_r <= S_SETUP;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SETUP: begin
                    xmin_r <= bb_xmin_s;
                    xmax_r <= bb_xmax_s;
                    ymin_r <= bb_ymin_s;
                    ymax_r <= bb_ymax_s;
                    x_r    <= bb_xmin_s;
                    y_r    <= bb_ymin_s;
                    if (area_s == 25'sd0) begin
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!stall_s) begin
                        if (inside_s) begin
                            px      <= x_r;
                            py      <= y_r;
                            p_valid <= 1'b1;
                        end else begin
                            p_valid <= 1'b0;
                        end
                        // x never steps past xmax, so the 11-bit counters cannot wrap.
                        if (x_r == xmax_r) begin
                            x_r <= xmin_r;
                            if (y_r == ymax_r) begin
                                state_r <= S_DRAIN;
                            end else begin
                                y_r <= y_r + 11'd1;
                            end
                        end else begin
                            x_r <= x_r + 11'd1;
                        end
                    end else begin
                        state_r <= S_SCAN;
                    end
                end
                S_DRAIN: begin
                    if (!p_valid || p_ready) begin
                        p_valid <= 1'b0;
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    p_valid <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Directed and randomized checks of triangle_rasterizer against a plain-arithmetic
// enumeration of the covered points.
module tb_triangle_rasterizer;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] ax, ay, bx, by, cx, cy;
    logic [10:0] px, py;
    logic        p_valid;
    logic        p_ready;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_q[$];
    int got_q[$];
    int exp_done;
    int basic_ref[10] = '{0, 4096, 8192, 12288, 1, 4097, 8193, 2, 4098, 3};

    triangle_rasterizer dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .ax       (ax),
        .ay       (ay),
        .bx       (bx),
        .by       (by),
        .cx       (cx),
        .cy       (cy),
        .px       (px),
        .py       (py),
        .p_valid  (p_valid),
        .p_ready  (p_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Reference: every lattice point of the bounding box whose three edge values share a sign.
    task automatic build_model(input int vax, input int vay, input int vbx, input int vby,
                               input int vcx, input int vcy);
        int d, xmin, xmax, ymin, ymax, e0, e1, e2;
        exp_q.delete();
        d    = (vbx - vax) * (vcy - vay) - (vby - vay) * (vcx - vax);
        xmin = (vax < vbx) ? vax : vbx;  xmin = (vcx < xmin) ? vcx : xmin;
        xmax = (vax > vbx) ? vax : vbx;  xmax = (vcx > xmax) ? vcx : xmax;
        ymin = (vay < vby) ? vay : vby;  ymin = (vcy < ymin) ? vcy : ymin;
        ymax = (vay > vby) ? vay : vby;  ymax = (vcy > ymax) ? vcy : ymax;
        if (d == 0) begin
            exp_done = 2;
        end else begin
            for (int y = ymin; y <= ymax; y++) begin
                for (int x = xmin; x <= xmax; x++) begin
                    e0 = (vbx - vax) * (y - vay) - (vby - vay) * (x - vax);
                    e1 = (vcx - vbx) * (y - vby) - (vcy - vby) * (x - vbx);
                    e2 = (vax - vcx) * (y - vcy) - (vay - vcy) * (x - vcx);
                    if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0))
                        exp_q.push_back(x * 4096 + y);
                end
            end
            exp_done = (xmax - xmin + 1) * (ymax - ymin + 1) + 3;
        end
    endtask

    // mode 0: always ready (timing checked), 1: alternating ready, 2: random ready.
    task automatic run_tri(input string tag, input int vax, input int vay, input int vbx,
                           input int vby, input int vcx, input int vcy, input int mode,
                           input bit pulse);
        int          cyc;
        bit          stall_prev, done_seen, busy_ok;
        logic [10:0] hold_x, hold_y;
        build_model(vax, vay, vbx, vby, vcx, vcy);
        got_q.delete();
        ax = 11'(vax); ay = 11'(vay); bx = 11'(vbx);
        by = 11'(vby); cx = 11'(vcx); cy = 11'(vcy);
        start = 1'b1;
        p_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        stall_prev = 1'b0;
        done_seen = 1'b0;
        busy_ok = 1'b1;
        hold_x = 11'd0;
        hold_y = 11'd0;
        while (cyc < 20000) begin
            if (stall_prev) begin
                check({tag, " hold_valid"}, 32'(p_valid), 32'd1);
                check({tag, " hold_px"}, 32'(px), 32'(hold_x));
                check({tag, " hold_py"}, 32'(py), 32'(hold_y));
            end
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (mode == 1) p_ready = (cyc % 2 == 0);
            else if (mode == 2) p_ready = 1'($urandom_range(0, 1));
            else p_ready = 1'b1;
            if (pulse && cyc == 5) begin
                start = 1'b1;
                ax = 11'd100; ay = 11'd200; bx = 11'd300;
                by = 11'd100; cx = 11'd50;  cy = 11'd400;
            end else begin
                start = 1'b0;
            end
            if (p_valid && p_ready) got_q.push_back(int'(px) * 4096 + int'(py));
            stall_prev = p_valid && !p_ready;
            hold_x = px;
            hold_y = py;
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, " done_seen"}, 32'(done_seen), 32'd1);
        check({tag, " busy_during_run"}, 32'(busy_ok), 32'd1);
        check({tag, " valid_at_done"}, 32'(p_valid), 32'd0);
        if (mode == 0) check({tag, " done_cycle"}, 32'(cyc), 32'(exp_done));
        check({tag, " point_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, " point"}, 32'(got_q[i]), 32'(exp_q[i]));
        p_ready = 1'b1;
        tick();
        check({tag, " busy_after_done"}, 32'(busy), 32'd0);
        check({tag, " done_pulse_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int acc, cyc, r0x, r0y;
        reset = 1'b1;
        start = 1'b0;
        p_ready = 1'b1;
        ax = 11'd0; ay = 11'd0; bx = 11'd0; by = 11'd0; cx = 11'd0; cy = 11'd0;
        tick();
        tick();
        check("reset px", 32'(px), 32'd0);
        check("reset py", 32'(py), 32'd0);
        check("reset p_valid", 32'(p_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        run_tri("basic", 0, 0, 3, 0, 0, 3, 0, 1'b0);
        check("basic count", 32'(got_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            check("basic literal", 32'(got_q[i]), 32'(basic_ref[i]));
        check("basic done_cycle", 32'(exp_done), 32'd19);

        run_tri("winding", 0, 0, 0, 3, 3, 0, 0, 1'b0);
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            check("winding literal", 32'(got_q[i]), 32'(basic_ref[i]));

        run_tri("degenerate", 5, 5, 10, 10, 15, 15, 0, 1'b0);

        run_tri("backpressure", 0, 0, 3, 0, 0, 3, 1, 1'b0);
        check("backpressure count", 32'(got_q.size()), 32'd10);

        run_tri("range", 2047, 2047, 2040, 2047, 2047, 2040, 0, 1'b0);
        check("range count", 32'(got_q.size()), 32'd36);
        for (int i = 0; i < got_q.size(); i++)
            check("range x+y", 32'((got_q[i] / 4096 + got_q[i] % 4096) >= 4087), 32'd1);

        run_tri("busy_start", 0, 0, 3, 0, 0, 3, 0, 1'b1);

        // Reset on the cycle of the fourth accept.
        ax = 11'd0; ay = 11'd0; bx = 11'd3; by = 11'd0; cx = 11'd0; cy = 11'd3;
        p_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = 0;
        cyc = 1;
        while (cyc < 200) begin
            if (p_valid && p_ready) acc++;
            if (acc == 4) break;
            tick();
            cyc++;
        end
        check("midreset reached_4th", 32'(acc), 32'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset p_valid", 32'(p_valid), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        tick();
        check("midreset no_done", 32'(done), 32'd0);
        run_tri("after_reset", 0, 0, 3, 0, 0, 3, 0, 1'b0);
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            check("after_reset literal", 32'(got_q[i]), 32'(basic_ref[i]));

        for (int t = 0; t < 8; t++) begin
            r0x = int'($urandom_range(0, 2017));
            r0y = int'($urandom_range(0, 2017));
            run_tri("random", r0x + int'($urandom_range(0, 30)), r0y + int'($urandom_range(0, 30)),
                    r0x + int'($urandom_range(0, 30)), r0y + int'($urandom_range(0, 30)),
                    r0x + int'($urandom_range(0, 30)), r0y + int'($urandom_range(0, 30)),
                    (t % 2 == 0) ? 0 : 2, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
